// File: rtl/risc_datapath_if.sv
// Control-strobe and data bundle between the control unit and the single-bus datapath.
interface risc_datapath_if;
  logic        pci, pco, iri, iro;
  logic [31:0] pc, pc_immediate, ir;
  logic        mari, maro, mdri, mdro, mem_read, mem_write;
  logic        opi, ipi, ipo;
  logic [31:0] input_unit;
  logic        ryi, ryo, csigno;
  logic        gra, grb, grc, rin, rout, baout;
  logic [31:0] output_unit, bus_out, ir_out;

  modport master (
    output pci, pco, iri, iro, pc, pc_immediate, ir,
           mari, maro, mdri, mdro, mem_read, mem_write,
           opi, ipi, ipo, input_unit, ryi, ryo, csigno,
           gra, grb, grc, rin, rout, baout,
    input  output_unit, bus_out, ir_out
  );

  modport slave (
    input  pci, pco, iri, iro, pc, pc_immediate, ir,
           mari, maro, mdri, mdro, mem_read, mem_write,
           opi, ipi, ipo, input_unit, ryi, ryo, csigno,
           gra, grb, grc, rin, rout, baout,
    output output_unit, bus_out, ir_out
  );
endinterface

// File: rtl/risc_datapath.sv
// 32-bit single-bus datapath: PC, IR, MAR, MDR, 16x32 register file, Y, I/O ports and word RAM,
// all joined by one combinational internal bus driven under one-hot control strobes.
module risc_datapath #(
   parameter int    MEM_WORDS = 512,
   parameter string MEM_INIT  = ""
) (
   input  logic            clock,
   input  logic            clear,
   risc_datapath_if.slave  dp
);
   localparam int AW = $clog2(MEM_WORDS);

   logic [31:0]       pc_q, ir_q, mar_q, mdr_q, y_q, inport_q, outport_q;
   logic [15:0][31:0] regs;
   logic [31:0]       mem [MEM_WORDS];
   logic [31:0]       bus, reg_val, csign, mem_rd;
   logic [15:0]       sel;
   logic [3:0]        lo_idx;
   logic [AW-1:0]     addr;

   // Debug inputs are reserved and intentionally have no effect.
   logic unused_dbg;
   assign unused_dbg = ^{dp.pc, dp.pc_immediate, dp.ir};

   assign addr   = mar_q[AW-1:0];
   assign mem_rd = mem[addr];
   assign csign  = {{13{ir_q[18]}}, ir_q[18:0]};

   always_comb begin
      sel = '0;
      if (dp.gra) sel[ir_q[26:23]] = 1'b1;
      if (dp.grb) sel[ir_q[22:19]] = 1'b1;
      if (dp.grc) sel[ir_q[18:15]] = 1'b1;
   end

   // Scan high to low so the lowest-numbered selected register wins.
   always_comb begin
      reg_val = '0;
      lo_idx  = '0;
      for (int i = 15; i >= 0; i--) begin
         if (sel[i]) begin
            reg_val = regs[i];
            lo_idx  = 4'(i);
         end
      end
   end

   always_comb begin
      bus = '0;
      if (dp.rout)        bus = reg_val;
      else if (dp.baout)  bus = (lo_idx == 4'd0) ? 32'h0 : reg_val;
      else if (dp.pco)    bus = pc_q;
      else if (dp.iro)    bus = ir_q;
      else if (dp.mdro)   bus = mdr_q;
      else if (dp.maro)   bus = mar_q;
      else if (dp.ryo)    bus = y_q;
      else if (dp.ipo)    bus = inport_q;
      else if (dp.csigno) bus = csign;
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         pc_q      <= '0;
         ir_q      <= '0;
         mar_q     <= '0;
         mdr_q     <= '0;
         y_q       <= '0;
         inport_q  <= '0;
         outport_q <= '0;
         regs      <= '0;
      end else begin
         if (dp.pci)  pc_q      <= bus;
         if (dp.iri)  ir_q      <= bus;
         if (dp.mari) mar_q     <= bus;
         if (dp.mdri) mdr_q     <= dp.mem_read ? mem_rd : bus;
         if (dp.ryi)  y_q       <= bus;
         if (dp.ipi)  inport_q  <= dp.input_unit;
         if (dp.opi)  outport_q <= bus;
         for (int i = 0; i < 16; i++)
            if (dp.rin && sel[i]) regs[i] <= bus;
      end
   end

   // RAM is not reset; a write during clear is dropped along with every other capture.
   always_ff @(posedge clock) begin
      if (dp.mem_write && !clear) mem[addr] <= mdr_q;
   end

   assign dp.bus_out     = bus;
   assign dp.ir_out      = ir_q;
   assign dp.output_unit = outport_q;
endmodule

// File: tb/tb_risc_datapath.sv
// Directed test of risc_datapath: bus priority, register select, memory path, I/O ports, reset.
module tb_risc_datapath;
  logic clock = 1'b0;
  logic clear = 1'b1;
  int   errs = 0, checks = 0;

  risc_datapath_if dp();
  risc_datapath #(.MEM_WORDS(512), .MEM_INIT("")) dut (.clock(clock), .clear(clear), .dp(dp));

  initial forever #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    {dp.pci, dp.pco, dp.iri, dp.iro, dp.mari, dp.maro, dp.mdri, dp.mdro} = '0;
    {dp.mem_read, dp.mem_write, dp.opi, dp.ipi, dp.ipo, dp.ryi, dp.ryo} = '0;
    {dp.csigno, dp.gra, dp.grb, dp.grc, dp.rin, dp.rout, dp.baout} = '0;
  endtask

  // Strobes set by the caller are captured at the next edge, then dropped.
  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic put_in(input logic [31:0] v);
    dp.input_unit = v; dp.ipi = 1; tick();
  endtask

  initial begin
    idle();
    dp.pc = 32'hFFFF_FFFF; dp.pc_immediate = 32'hA5A5_A5A5; dp.ir = 32'h5A5A_5A5A;
    dp.input_unit = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_bus", dp.bus_out, 32'h0);
    chk("rst_ir", dp.ir_out, 32'h0);
    chk("rst_out", dp.output_unit, 32'h0);
    clear = 1'b0;

    // Seed MEM[0] = 0080_0000 through the in-port and MDR (MAR is 0 after reset).
    put_in(32'h0080_0000);
    dp.ipo = 1; dp.mdri = 1; tick();
    dp.mdro = 1; #1 chk("mdr_from_bus", dp.bus_out, 32'h0080_0000); idle();
    dp.mem_write = 1; tick();

    // PC load/drive.
    put_in(32'h0000_0055);
    dp.ipo = 1; dp.pci = 1; tick();
    dp.pco = 1; #1 chk("pc_rd", dp.bus_out, 32'h55); idle();

    // R0 = 55, then baout reads it as 0 while rout reads 55.
    dp.ipo = 1; dp.gra = 1; dp.rin = 1; tick();
    dp.gra = 1; dp.rout = 1; #1 chk("r0_rout", dp.bus_out, 32'h55); idle();
    dp.ipo = 1; dp.mari = 1; tick();
    dp.maro = 1; #1 chk("mar_55", dp.bus_out, 32'h55); idle();
    dp.gra = 1; dp.baout = 1; dp.mari = 1; #1 chk("r0_baout", dp.bus_out, 32'h0); tick();
    dp.maro = 1; #1 chk("mar_0", dp.bus_out, 32'h0); idle();

    // MDR from RAM.
    dp.csigno = 1; dp.mdri = 1; tick();
    dp.mdro = 1; #1 chk("mdr_zero", dp.bus_out, 32'h0); idle();
    dp.mdri = 1; dp.mem_read = 1; tick();
    dp.mdro = 1; #1 chk("mdr_mem0", dp.bus_out, 32'h0080_0000); idle();

    // IR load; Ra = R1. R1 = 55, then rin with no driver clears it.
    dp.mdro = 1; dp.iri = 1; tick();
    chk("ir_load", dp.ir_out, 32'h0080_0000);
    dp.ipo = 1; dp.gra = 1; dp.rin = 1; tick();
    dp.gra = 1; dp.rout = 1; #1 chk("r1_55", dp.bus_out, 32'h55); idle();
    dp.gra = 1; dp.rin = 1; tick();
    dp.gra = 1; dp.rout = 1; #1 chk("r1_nodrv", dp.bus_out, 32'h0); idle();

    // R1 = DEADBEEF via MDR, then out-port.
    put_in(32'hDEAD_BEEF);
    dp.ipo = 1; dp.mdri = 1; tick();
    dp.mdro = 1; dp.gra = 1; dp.rin = 1; tick();
    dp.gra = 1; dp.rout = 1; dp.opi = 1; tick();
    chk("outport", dp.output_unit, 32'hDEAD_BEEF);
    dp.pco = 1; tick();
    chk("outport_hold", dp.output_unit, 32'hDEAD_BEEF);
    dp.gra = 1; dp.rout = 1; dp.rin = 1; tick();
    dp.gra = 1; dp.rout = 1; #1 chk("self_reload", dp.bus_out, 32'hDEAD_BEEF); idle();

    // Priority: rout over pco, mdro over maro, maro over ipo.
    dp.gra = 1; dp.rout = 1; dp.pco = 1; #1 chk("pri_rout_pc", dp.bus_out, 32'hDEAD_BEEF); idle();
    dp.pco = 1; dp.iro = 1; #1 chk("pri_pc_ir", dp.bus_out, 32'h55); idle();
    dp.mdro = 1; dp.maro = 1; dp.ipo = 1; #1 chk("pri_mdr_mar", dp.bus_out, 32'hDEAD_BEEF); idle();
    dp.maro = 1; dp.ipo = 1; #1 chk("pri_mar_ip", dp.bus_out, 32'h0); idle();

    // Sign extension: IR[18:0] = 40000 -> FFFC_0000 through Y.
    put_in(32'h0004_0000);
    dp.ipo = 1; dp.iri = 1; tick();
    dp.csigno = 1; dp.ryi = 1; tick();
    dp.ryo = 1; #1 chk("y_csign", dp.bus_out, 32'hFFFC_0000); idle();
    put_in(32'h0003_FFFF);
    dp.ipo = 1; dp.iri = 1; tick();
    dp.csigno = 1; #1 chk("csign_pos", dp.bus_out, 32'h0003_FFFF); idle();

    // Address wrap: MAR = 1234_5678 writes word 0x078.
    put_in(32'h1234_5678);
    dp.ipo = 1; dp.mari = 1; tick();
    put_in(32'h5);
    dp.ipo = 1; dp.mdri = 1; tick();
    dp.mem_write = 1; tick();
    put_in(32'h278);
    dp.ipo = 1; dp.mari = 1; dp.mdri = 1; tick();
    dp.mdri = 1; dp.mem_read = 1; tick();
    dp.mdro = 1; #1 chk("mem_wrap", dp.bus_out, 32'h5); idle();
    // Write + load together: RAM gets old MDR (5 -> 0x078 again), MDR gets the bus.
    put_in(32'h77);
    dp.ipo = 1; dp.mdri = 1; dp.mem_write = 1; tick();
    dp.mdro = 1; #1 chk("mdr_new", dp.bus_out, 32'h77); idle();
    dp.mdri = 1; dp.mem_read = 1; tick();
    dp.mdro = 1; #1 chk("mem_oldmdr", dp.bus_out, 32'h5); idle();
    put_in(32'h0);
    dp.ipo = 1; dp.mari = 1; tick();
    dp.mdri = 1; dp.mem_read = 1; tick();
    dp.mdro = 1; #1 chk("mem0_kept", dp.bus_out, 32'h0080_0000); idle();

    // Mid-run clear: immediate zero, and a capture in that cycle is dropped.
    put_in(32'hCAFE_F00D);
    dp.ipo = 1; dp.opi = 1; tick();
    chk("out_pre_clr", dp.output_unit, 32'hCAFE_F00D);
    dp.ipo = 1;
    clear = 1'b1;
    #1;
    chk("clr_bus", dp.bus_out, 32'h0);
    chk("clr_out", dp.output_unit, 32'h0);
    chk("clr_ir", dp.ir_out, 32'h0);
    dp.input_unit = 32'h1111_1111; dp.ipi = 1; dp.pci = 1;
    @(posedge clock); #1;
    idle();
    clear = 1'b0;
    dp.ipo = 1; #1 chk("clr_abort_ip", dp.bus_out, 32'h0); idle();
    dp.pco = 1; #1 chk("clr_pc", dp.bus_out, 32'h0); idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
